// File: rtl/btb_update_scheduler_pkg.sv
// Shared types and width helpers for the BTB update scheduler and its update FIFO.
package btb_sched_pkg;

    localparam int unsigned PC_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } btb_upd_t;

    localparam int unsigned UPD_W = 2 * PC_W + 1;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO of resolved-branch updates; extra pointer bit separates full from empty.
module btb_update_fifo
    import btb_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  btb_upd_t push_data,
    input  logic     pop,
    input  logic     flush,
    output btb_upd_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = idx_w(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    btb_upd_t    mem_q [DEPTH];
    btb_upd_t    mem_d [DEPTH];

    // Status flags and head entry.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for storage and pointers; flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/btb_update_scheduler.sv
// Arbitrates the single BTB port between fetch lookups, queued branch updates
// and a full-table invalidation sweep triggered by flush_all.
module btb_update_scheduler
    import btb_sched_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BTB_ENTRIES  = 64,
    parameter int unsigned STARVE_LIMIT = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          res_valid,
    input  logic [31:0]                   res_pc,
    input  logic [31:0]                   res_target,
    input  logic                          res_taken,
    output logic                          res_ready,
    input  logic                          fetch_req,
    output logic                          fetch_grant,
    input  logic                          flush_all,
    output logic                          btb_wr_en,
    output logic [31:0]                   btb_wr_pc,
    output logic [31:0]                   btb_wr_target,
    output logic                          btb_wr_valid,
    output logic                          btb_inv_en,
    output logic [idx_w(BTB_ENTRIES)-1:0] btb_inv_idx,
    output logic                          busy
);

    localparam int unsigned IW = idx_w(BTB_ENTRIES);
    localparam int unsigned SW = idx_w(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [IW-1:0] LAST_IDX   = IW'(BTB_ENTRIES - 1);

    sched_state_e  state_q, state_d;
    logic [IW-1:0] sweep_idx_q, sweep_idx_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    btb_upd_t push_data_s;
    btb_upd_t head_s;
    logic     fifo_full_s;
    logic     fifo_empty_s;
    logic     push_s;
    logic     drain_s;
    logic     idle_s;

    // Port arbitration: decisions depend only on registered state, fetch_req and flush_all.
    always_comb begin
        idle_s      = (state_q == ST_IDLE);
        res_ready   = !fifo_full_s && idle_s && !flush_all;
        drain_s     = idle_s && !flush_all && !fifo_empty_s &&
                      (!fetch_req || fifo_full_s || (starve_cnt_q == STARVE_MAX));
        fetch_grant = fetch_req && idle_s && !drain_s;
        push_s      = res_valid && res_ready;
        push_data_s = '{pc: res_pc, target: res_target, taken: res_taken};
    end

    // BTB port outputs; data buses are held at zero when not in use.
    always_comb begin
        btb_wr_en = drain_s;
        if (drain_s) begin
            btb_wr_pc     = head_s.pc;
            btb_wr_target = head_s.target;
            btb_wr_valid  = head_s.taken;
        end else begin
            btb_wr_pc     = 32'h0000_0000;
            btb_wr_target = 32'h0000_0000;
            btb_wr_valid  = 1'b0;
        end
        btb_inv_en  = (state_q == ST_SWEEP);
        busy        = (state_q == ST_SWEEP);
        btb_inv_idx = (state_q == ST_SWEEP) ? sweep_idx_q : '0;
    end

    // Sweep FSM; a flush in either state (re)starts the sweep at index 0.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (flush_all) begin
            state_d     = ST_SWEEP;
            sweep_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_IDLE;
                    sweep_idx_d = sweep_idx_q;
                end
                ST_SWEEP: begin
                    sweep_idx_d = sweep_idx_q + {{(IW-1){1'b0}}, 1'b1};
                    if (sweep_idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SWEEP;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    sweep_idx_d = '0;
                end
            endcase
        end
    end

    // Starvation counter: counts lookups granted while updates wait.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty_s || drain_s || flush_all) begin
            starve_cnt_d = '0;
        end else if (fetch_grant && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sweep_idx_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    btb_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (drain_s),
        .flush     (flush_all),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Table-driven bench for btb_update_scheduler with a scoreboard of queued updates.
module tb_btb_update_scheduler;
    import btb_sched_pkg::*;

    logic        clk;
    logic        reset;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        res_ready;
    logic        fetch_req;
    logic        fetch_grant;
    logic        flush_all;
    logic        btb_wr_en;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        btb_wr_valid;
    logic        btb_inv_en;
    logic [5:0]  btb_inv_idx;
    logic        busy;

    btb_update_scheduler #(
        .DEPTH        (4),
        .BTB_ENTRIES  (64),
        .STARVE_LIMIT (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_target    (res_target),
        .res_taken     (res_taken),
        .res_ready     (res_ready),
        .fetch_req     (fetch_req),
        .fetch_grant   (fetch_grant),
        .flush_all     (flush_all),
        .btb_wr_en     (btb_wr_en),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_target (btb_wr_target),
        .btb_wr_valid  (btb_wr_valid),
        .btb_inv_en    (btb_inv_en),
        .btb_inv_idx   (btb_inv_idx),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
        logic        fr;
        logic        fl;
        logic        e_rdy;
        logic        e_gnt;
        logic        e_wr;
        logic        e_inv;
        logic        e_busy;
    } vec_t;

    vec_t     vecs[$];
    btb_upd_t sb[$];
    int       checks = 0;
    int       errors = 0;

    function automatic vec_t mk(logic rv, logic [31:0] pc, logic [31:0] tgt, logic tk,
                                logic fr, logic fl, logic e_rdy, logic e_gnt,
                                logic e_wr, logic e_inv, logic e_busy);
        vec_t v;
        v.rv = rv; v.pc = pc; v.tgt = tgt; v.tk = tk; v.fr = fr; v.fl = fl;
        v.e_rdy = e_rdy; v.e_gnt = e_gnt; v.e_wr = e_wr; v.e_inv = e_inv; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, compare just after, update the scoreboard.
    task automatic apply(input vec_t v, input string tag);
        btb_upd_t exp_u;
        @(negedge clk);
        res_valid  = v.rv;
        res_pc     = v.pc;
        res_target = v.tgt;
        res_taken  = v.tk;
        fetch_req  = v.fr;
        flush_all  = v.fl;
        #1;
        chk({tag, " res_ready"},   {31'd0, res_ready},   {31'd0, v.e_rdy});
        chk({tag, " fetch_grant"}, {31'd0, fetch_grant}, {31'd0, v.e_gnt});
        chk({tag, " btb_wr_en"},   {31'd0, btb_wr_en},   {31'd0, v.e_wr});
        chk({tag, " btb_inv_en"},  {31'd0, btb_inv_en},  {31'd0, v.e_inv});
        chk({tag, " busy"},        {31'd0, busy},        {31'd0, v.e_busy});
        if (btb_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s wr_unexpected: got write pc %0h expected no write", tag, btb_wr_pc);
            end else begin
                exp_u = sb.pop_front();
                chk({tag, " wr_pc"},     btb_wr_pc,     exp_u.pc);
                chk({tag, " wr_target"}, btb_wr_target, exp_u.target);
                chk({tag, " wr_valid"},  {31'd0, btb_wr_valid}, {31'd0, exp_u.taken});
            end
        end
        if (v.rv && v.e_rdy) begin
            sb.push_back('{pc: v.pc, target: v.tgt, taken: v.tk});
        end
        if (v.fl) begin
            sb.delete();
        end
    endtask

    // Run count sweep cycles checking the index sequence; optionally flush at flush_at.
    task automatic sweep_cycles(input int count, input int flush_at, input string tag);
        for (int i = 0; i < count; i++) begin
            apply(mk(1'b1, 32'h900 + i, 32'h990, 1'b1, 1'b1, (i == flush_at),
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1), tag);
            chk({tag, " inv_idx"}, {26'd0, btb_inv_idx}, i);
        end
    endtask

    initial begin
        reset = 1'b1; res_valid = 1'b0; res_pc = 32'h0; res_target = 32'h0;
        res_taken = 1'b0; fetch_req = 1'b0; flush_all = 1'b0;
        #2;
        chk("rst res_ready",   {31'd0, res_ready},   32'd1);
        chk("rst fetch_grant", {31'd0, fetch_grant}, 32'd0);
        chk("rst btb_wr_en",   {31'd0, btb_wr_en},   32'd0);
        chk("rst btb_inv_en",  {31'd0, btb_inv_en},  32'd0);
        chk("rst busy",        {31'd0, busy},        32'd0);
        chk("rst wr_pc",       btb_wr_pc,            32'd0);
        chk("rst wr_target",   btb_wr_target,        32'd0);
        chk("rst inv_idx",     {26'd0, btb_inv_idx}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //          rv    pc        tgt       tk    fr    fl    rdy   gnt   wr    inv   busy
        // single taken push, no fetch: written next cycle
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        // not-taken push under continuous fetch: 7 grants then a forced write
        vecs.push_back(mk(1'b1, 32'h200, 32'h240, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        // fill to full under fetch; full forces drain and refuses a fifth push
        vecs.push_back(mk(1'b1, 32'h300, 32'h340, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h304, 32'h344, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h308, 32'h348, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h30c, 32'h34c, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h310, 32'h350, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // flush with three queued entries: no writes, 64-cycle sweep, then empty IDLE
        apply(mk(1'b1, 32'h400, 32'h440, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "fl_push0");
        apply(mk(1'b1, 32'h404, 32'h444, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "fl_push1");
        apply(mk(1'b1, 32'h408, 32'h448, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "fl_push2");
        apply(mk(1'b1, 32'h40c, 32'h44c, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fl_cycle");
        sweep_cycles(64, -1, "sweep1");
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "post1_a");
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "post1_b");

        // re-flush at index 20 restarts a full sweep
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fl2_cycle");
        sweep_cycles(21, 20, "sweep2a");
        sweep_cycles(64, -1, "sweep2b");
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "post2");

        // asynchronous reset in the middle of a sweep
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fl3_cycle");
        sweep_cycles(11, -1, "sweep3");
        res_valid = 1'b0; fetch_req = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midrst btb_inv_en", {31'd0, btb_inv_en},  32'd0);
        chk("midrst busy",       {31'd0, busy},        32'd0);
        chk("midrst inv_idx",    {26'd0, btb_inv_idx}, 32'd0);
        chk("midrst res_ready",  {31'd0, res_ready},   32'd1);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "postrst_a");
        apply(mk(1'b1, 32'h500, 32'h540, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "postrst_b");
        apply(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "postrst_c");

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_update_scheduler.md
# btb_update_scheduler

Shares the branch target buffer's single access port between fetch-stage lookups and MEM-stage update traffic. Resolved branches are queued in a small FIFO and drained into the BTB in cycles that fetch leaves idle. Starvation and full-queue conditions force a drain. A flush request runs a full-table invalidation sweep. The block sits between the MEM-stage branch resolution logic, the fetch-stage predictor and the BTB write/invalidate port.

## Interface
Parameters:
- DEPTH, 4 — update FIFO entries (power of two, ≥2)
- BTB_ENTRIES, 64 — BTB index count (power of two)
- STARVE_LIMIT, 7 — max consecutive cycles a non-empty FIFO may be denied the port

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- res_valid  in  1  MEM stage presents a resolved branch
- res_pc  in  32  PC of the resolved branch
- res_target  in  32  computed target (pc + offset)
- res_taken  in  1  actual branch decision
- res_ready  out  1  FIFO accepts the entry this cycle
- fetch_req  in  1  fetch wants a BTB lookup this cycle
- fetch_grant  out  1  lookup owns the BTB port this cycle
- flush_all  in  1  one-cycle pulse: invalidate the whole BTB
- btb_wr_en  out  1  write the entry described below
- btb_wr_pc  out  32  FIFO head PC
- btb_wr_target  out  32  FIFO head target
- btb_wr_valid  out  1  1 = install (taken), 0 = invalidate (not taken)
- btb_inv_en  out  1  sweep invalidation strobe
- btb_inv_idx  out  log2(BTB_ENTRIES)  index being invalidated
- busy  out  1  sweep in progress

## Operation
- States: IDLE, SWEEP. Reset → IDLE, FIFO empty, starve_cnt=0, sweep_idx=0.
- Reset output values: res_ready=1, fetch_grant=0, btb_wr_en=0, btb_inv_en=0, busy=0. All data outputs read 0.
- Push: res_valid & res_ready. res_ready = !full & state==IDLE & !flush_all. A push while full is not allowed, even if a pop occurs in the same cycle.
- In IDLE, drain this cycle = !empty & (!fetch_req | full | starve_cnt==STARVE_LIMIT).
- btb_wr_en = drain. btb_wr_* = FIFO head. btb_wr_valid = head.taken. The pop happens at the same edge.
- fetch_grant = fetch_req & state==IDLE & !drain.
- starve_cnt: cleared on pop or when empty. It increments when !empty & fetch_grant. It saturates at STARVE_LIMIT.
- flush_all in IDLE or SWEEP:
  - FIFO is emptied, and any same-cycle push is refused.
  - sweep_idx is set to 0 and the next state is SWEEP.
  - A drain in that cycle is suppressed (btb_wr_en=0).
- SWEEP:
  - btb_inv_en=1, btb_inv_idx=sweep_idx, busy=1.
  - fetch_grant=0, res_ready=0.
  - sweep_idx increments each cycle.
  - After idx BTB_ENTRIES-1 is issued, the next state is IDLE.
- Asserting reset mid-sweep or mid-drain aborts immediately to the reset values.

## Timing
- Push-to-earliest-write latency: 1 cycle. An entry pushed at edge N can be written in cycle N+1.
- Port decisions (drain, fetch_grant) are combinational from registered state plus fetch_req and flush_all. There is no path from res_valid to btb_wr_en.
- A sweep lasts exactly BTB_ENTRIES cycles. The flush cycle itself is not a sweep cycle.
- btb_wr_en, btb_inv_en and fetch_grant are mutually exclusive in every cycle.
- Worst-case update wait under continuous fetch_req: STARVE_LIMIT cycles, or 0 when the FIFO is full.

## Structure
- Package btb_sched_pkg holds:
  - state enum {IDLE, SWEEP}
  - struct btb_upd_t {pc[31:0], target[31:0], taken}
  - localparam width helpers
- Sub-module btb_update_fifo is a synchronous FIFO of btb_upd_t, DEPTH entries, with full/empty flags and asynchronous reset. Pointers are one bit wider than the index.
- The top level holds the arbitration logic, starve_cnt, the state register and sweep_idx.

## Test plan
- Reset, fetch_req=0, one push (pc=0x100, target=0x140, taken=1) → cycle+1: btb_wr_en=1, wr_pc=0x100, wr_target=0x140, wr_valid=1. FIFO then empty.
- fetch_req held 1, one not-taken push → fetch_grant=1 for 7 cycles, then btb_wr_en=1 with wr_valid=0 and fetch_grant=0 for one cycle.
- 4 pushes with fetch_req=1 → res_ready=0 when full. The next cycle drains despite fetch_req. res_ready returns to 1 after the pop.
- flush_all with 3 entries queued → no writes issued. 64 cycles of btb_inv_en with idx 0..63, busy=1, fetch_grant=0. Then IDLE with an empty FIFO.
- flush_all again at sweep idx 20 → idx restarts at 0 and the sweep lasts a full 64 more cycles.
- Reset asserted mid-sweep at idx 10, asynchronously between edges → btb_inv_en and busy drop immediately. After release: IDLE, res_ready=1.
